// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and types for the execute-stage divider.
//   - operand width, iteration count and counter width
//   - divider state encodings
//   - DIV/DIVU funct codes used by the main decoder
//   - {HI, LO} result payload and sign helpers
package div_unit_pkg;

   localparam int unsigned DW       = 32;
   localparam int unsigned DIV_ITER = DW;
   localparam int unsigned CW       = $clog2(DIV_ITER);

   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU = 6'b011011;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_ON   = 2'd2,
      DIV_END  = 2'd3
   } div_state_e;

   // HI carries the remainder, LO the quotient
   typedef struct packed {
      logic [DW-1:0] rem;
      logic [DW-1:0] quo;
   } div_result_t;

   // Two's-complement negate when en is set
   function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] x, input logic en);
      return en ? DW'(~x + DW'(1)) : x;
   endfunction

   // Unsigned magnitude; 0x80000000 maps to 2^31, which fits the unsigned register
   function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] x, input logic is_signed);
      return neg_if(x, is_signed & x[DW-1]);
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i  : partial remainder (DW+1 bits)
//   dvs_i  : divisor magnitude
//   bit_i  : next dividend bit shifted in
//   rem_o  : updated partial remainder
//   qbit_o : quotient bit produced by this step
module div_step
   import div_unit_pkg::*;
(
   input  logic [DW:0]   rem_i,
   input  logic [DW-1:0] dvs_i,
   input  logic          bit_i,
   output logic [DW:0]   rem_o,
   output logic          qbit_o
);

   logic [DW+1:0] shifted;
   logic [DW+1:0] diff;

   // Extra top bit holds the borrow of the trial subtraction
   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {2'b00, dvs_i};
   assign qbit_o  = ~diff[DW+1];
   assign rem_o   = diff[DW+1] ? shifted[DW:0] : diff[DW:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//   clk, resetn         : clock, asynchronous active-low reset
//   start, signed_div   : DIV/DIVU request (level) and signedness, sampled in IDLE
//   opdata1, opdata2    : dividend (rs) and divisor (rt), sampled in IDLE
//   annul               : flush/exception, aborts any operation
//   result              : {remainder (HI), quotient (LO)}, held between completions
//   ready               : one-cycle completion pulse
//   stall_div           : combinational stall request to the hazard unit
// Optional build macro DIV_EARLY_EXIT_EN: operations with |op1| < |op2| skip
// the iteration loop and complete with the divide-by-zero latency.
module div_unit
   import div_unit_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            signed_div,
   input  logic [DW-1:0]   opdata1,
   input  logic [DW-1:0]   opdata2,
   input  logic            annul,
   output logic [2*DW-1:0] result,
   output logic            ready,
   output logic            stall_div
);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [DW-1:0] dvs_q, dvs_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [DW:0]   rem_q, rem_d;
   logic          negq_q, negq_d;
   logic          negr_q, negr_d;
   logic          early_q, early_d;
   div_result_t   result_q, result_d;
   logic          ready_q, ready_d;

   logic [DW-1:0] op1_mag, op2_mag;
   logic [DW:0]   step_rem;
   logic          step_qbit;
   logic [DW-1:0] step_quo;

   assign op1_mag  = abs_mag(opdata1, signed_div);
   assign op2_mag  = abs_mag(opdata2, signed_div);
   assign step_quo = DW'({quo_q, step_qbit});

   div_step u_step (
      .rem_i  (rem_q),
      .dvs_i  (dvs_q),
      .bit_i  (dvd_q[DW-1]),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   // Next-state, datapath and completion logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      early_d  = early_q;
      result_d = result_q;
      ready_d  = 1'b0;

      unique case (state_q)
         DIV_IDLE: begin
            if (start && !annul) begin
               dvd_d   = op1_mag;
               dvs_d   = op2_mag;
               quo_d   = '0;
               rem_d   = '0;
               cnt_d   = '0;
               negq_d  = signed_div & (opdata1[DW-1] ^ opdata2[DW-1]);
               negr_d  = signed_div & opdata1[DW-1];
               early_d = 1'b0;
               if (opdata2 == '0) begin
                  // All-ones quotient must not be sign-fixed
                  negq_d  = 1'b0;
                  state_d = DIV_ZERO;
`ifdef DIV_EARLY_EXIT_EN
               end else if (op1_mag < op2_mag) begin
                  // Reuse the ZERO slot so both short paths share one latency
                  early_d = 1'b1;
                  state_d = DIV_ZERO;
`endif
               end else begin
                  state_d = DIV_ON;
               end
            end
         end

         DIV_ZERO: begin
            // Sign-fixed magnitude restores the original dividend as remainder
            result_d.rem = neg_if(dvd_q, negr_q);
            result_d.quo = early_q ? '0 : '1;
            ready_d      = 1'b1;
            state_d      = DIV_END;
         end

         DIV_ON: begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvd_d = dvd_q << 1;
            cnt_d = CW'(cnt_q + 1'b1);
            if (cnt_q == CW'(DIV_ITER - 1)) begin
               // Final result registered on entry to END so ready is a flop
               result_d.rem = neg_if(step_rem[DW-1:0], negr_q);
               result_d.quo = neg_if(step_quo, negq_q);
               ready_d      = 1'b1;
               state_d      = DIV_END;
            end
         end

         DIV_END: begin
            state_d = DIV_IDLE;
         end

         default: begin
            state_d = DIV_IDLE;
         end
      endcase

      // Abort wins over everything, including a completion this edge
      if (annul) begin
         state_d  = DIV_IDLE;
         ready_d  = 1'b0;
         result_d = result_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         early_q  <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         early_q  <= early_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result    = result_q;
   assign ready     = ready_q;
   assign stall_div = start & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. A per-cycle reference model
// (plain integer division plus a latency count) checks ready, result and
// stall_div; directed cases pin literal results and latencies.
module tb_div_unit;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stall_div;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   div_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stall_div  (stall_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: truncating integer division on 64-bit values
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Cycles from the accept cycle to the ready cycle
   function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
      longint ma, mb;
`endif
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
      ma = s ? longint'($signed(a)) : longint'(a);
      mb = s ? longint'($signed(b)) : longint'(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 2;
`endif
      return 33;
   endfunction

   // Cycle-level model: busy countdown, ready cycle, held result
   logic        m_busy  = 1'b0;
   logic        m_ready = 1'b0;
   int          m_left  = 0;
   logic [63:0] m_res   = '0;
   logic [63:0] m_pend  = '0;

   always @(negedge clk) begin
      if (!resetn) begin
         m_busy  = 1'b0;
         m_ready = 1'b0;
         m_left  = 0;
         m_res   = '0;
      end
      chk("ready", 64'(ready), 64'(m_ready));
      chk("result", result, m_res);
      chk("stall_div", 64'(stall_div), 64'(start & ~m_ready));
      if (resetn) begin
         if (annul) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
         end else if (m_ready) begin
            m_ready = 1'b0;
         end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy  = 1'b0;
               m_ready = 1'b1;
               m_res   = m_pend;
            end
         end else if (start) begin
            m_busy = 1'b1;
            m_left = ref_lat(signed_div, opdata1, opdata2) - 1;
            m_pend = ref_div(signed_div, opdata1, opdata2);
         end
      end
   end

   // Issue one operation (called just after a rising edge with the unit idle).
   // Returns at the same phase in the cycle after ready, start still high.
   // annul_at > 0 pulses annul in that cycle after accept; lat = -1 then.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int annul_at, output int lat, output logic [63:0] res,
                         output int rdy_cyc);
      lat        = -1;
      rdy_cyc    = -1;
      signed_div = s;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ready) begin
            lat     = i;
            rdy_cyc = cyc;
            chk("stall_in_ready", 64'(stall_div), 64'd0);
            break;
         end
         @(posedge clk);
         #1;
         if (annul) begin
            annul = 1'b0;
            start = 1'b0;
            res   = result;
            return;
         end
         if (i + 1 == annul_at) annul = 1'b1;
      end
      res = result;
      if (lat < 0) chk("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      annul = 1'b0;
   endtask

   int          lat, lat2, rc1, rc2;
   logic [63:0] res;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn     = 1'b0;
      start      = 1'b0;
      signed_div = 1'b0;
      opdata1    = '0;
      opdata2    = '0;
      annul      = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("reset_result", result, 64'd0);
      chk("reset_ready", 64'(ready), 64'd0);
      @(posedge clk);
      #1;

      // DIVU 100/7 with start held
      run_op(1'b0, 32'd100, 32'd7, -1, lat, res, rc1);
      chk("divu_100_7_lat", 64'(lat), 64'd33);
      chk("divu_100_7_res", res, {32'd2, 32'd14});
      start = 1'b0;

      // DIV -7/2
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat, res, rc1);
      chk("div_m7_2_res", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      start = 1'b0;

      // Signed overflow
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, res, rc1);
      chk("div_ovf_res", res, {32'd0, 32'h8000_0000});
      start = 1'b0;

      // Divide by zero
      run_op(1'b0, 32'd5, 32'd0, -1, lat, res, rc1);
      chk("divu_5_0_lat", 64'(lat), 64'd2);
      chk("divu_5_0_res", res, {32'd5, 32'hFFFF_FFFF});
      start = 1'b0;

      // Abort on ON cycle 10, then a fresh operation
      run_op(1'b0, 32'd1000, 32'd3, 10, lat, res, rc1);
      chk("annul_no_ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("annul_result_kept", result, {32'd5, 32'hFFFF_FFFF});
      @(posedge clk);
      #1;
      run_op(1'b0, 32'd9, 32'd3, -1, lat, res, rc1);
      chk("divu_9_3_lat", 64'(lat), 64'd33);
      chk("divu_9_3_res", res, {32'd0, 32'd3});

      // Back-to-back with start never dropping
      run_op(1'b0, 32'd50, 32'd5, -1, lat, res, rc1);
      chk("b2b_first_res", res, {32'd0, 32'd10});
      run_op(1'b0, 32'd7, 32'd7, -1, lat2, res, rc2);
      chk("b2b_second_res", res, {32'd0, 32'd1});
      chk("b2b_spacing", 64'(rc2 - rc1), 64'd34);
      start = 1'b0;

      // Dividend smaller than divisor
      run_op(1'b0, 32'd3, 32'd10, -1, lat, res, rc1);
`ifdef DIV_EARLY_EXIT_EN
      chk("divu_3_10_lat", 64'(lat), 64'd2);
`else
      chk("divu_3_10_lat", 64'(lat), 64'd33);
`endif
      chk("divu_3_10_res", res, {32'd3, 32'd0});
      start = 1'b0;

      // Reset in the middle of an operation
      signed_div = 1'b0;
      opdata1    = 32'd77;
      opdata2    = 32'd4;
      start      = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      resetn = 1'b0;
      start  = 1'b0;
      #1;
      chk("midreset_result", result, 64'd0);
      chk("midreset_ready", 64'(ready), 64'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;

      // Randomized operations, occasional aborts and idle gaps
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a, b;
         logic        s;
         int          ab;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       a = 32'd0;
            1:       a = 32'h8000_0000;
            2:       a = 32'hFFFF_FFFF;
            3:       a = 32'($urandom_range(0, 20));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'h8000_0000;
            3:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : -1;
         if (ab > 0 && ref_lat(s, a, b) <= ab) ab = -1;
         run_op(s, a, b, ab, lat, res, rc1);
         if (ab < 0) chk("rand_lat", 64'(lat), 64'(ref_lat(s, a, b)));
         if ($urandom_range(0, 2) == 0) begin
            start = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      start = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
